llr_frame_loader: RTL and testbench
===================================

// Module: llr_frame_loader
// PURPOSE
//  Upstream input stage of the LDPC decoder. Accepts channel LLR samples over a valid/ready stream.
//  Converts each sample to decoder width and buffers whole codewords in two ping-pong banks.
//  Streams each codeword to the decoder's i_data/i_val port, one LLR per clk.
//  Decoding of frame k overlaps with loading of frame k+1.
// PARAMETERS
//  N         12  LLRs per codeword (decoder ROW_NUMBER)
//  IN_WIDTH  8   signed channel sample width
//  WIDTH     6   signed decoder LLR width (WIDTH < IN_WIDTH)
// PORTS
//  clk       in   1         system clock; all logic on posedge
//  xrst      in   1         reset, asynchronous, active-low
//  s_data    in   IN_WIDTH  signed channel LLR, sample 0 of a frame first
//  s_val     in   1         s_data valid
//  s_rdy     out  1         loader can accept; transfer = s_val & s_rdy
//  dec_rdy   in   1         decoder idle, may take a new frame
//  o_data    out  WIDTH     signed LLR to decoder i_data
//  o_val     out  1         o_data valid (decoder i_val)
//  o_sof     out  1         with o_val: LLR index 0
//  o_eof     out  1         with o_val: LLR index N-1
//  frame_cnt out  16        frames fully streamed, wraps 0xFFFF->0
//  sat_cnt   out  16        clipped samples, saturates at 0xFFFF
// BEHAVIOUR
//  Reset (xrst=0, any time, incl. mid-frame):
//   - all outputs 0; s_rdy rises on the first clk edge after release
//   - full[1:0]=0, wr_bank=rd_bank=0, indices 0, FSM=IDLE
//   - bank contents undefined and never read before rewrite
//  Write side:
//   - each transfer stores conv(s_data) at bank[wr_bank][wr_idx] and increments wr_idx
//   - on the Nth transfer: full[wr_bank]<=1, wr_idx<=0, wr_bank toggles
//   - s_rdy = !full[wr_bank] (registered); both banks full -> s_rdy=0 until one frees
//  Read FSM:
//   - IDLE: full[rd_bank] & dec_rdy -> STREAM, rd_idx=0
//   - STREAM: o_val=1 and o_data=bank[rd_bank][rd_idx], all registered; rd_idx++
//   - at rd_idx=N-1: o_eof=1, full[rd_bank]<=0, rd_bank toggles, frame_cnt++, -> IDLE
//  Timing:
//   - dec_rdy is sampled only in IDLE; deassertion during STREAM is ignored (no gaps)
//   - latency: first o_val 2 clk after the accept edge of the Nth sample, when dec_rdy=1
//   - back-to-back frames: >=1 idle cycle between o_eof and the next o_sof
//  Simultaneous events:
//   - a bank freeing on o_eof and the other bank filling in the same cycle are both applied
//   - a freed bank is writable (s_rdy=1) the next cycle
// CONFIGURATION
//  LLR_SAT_EN defined:
//   - conv = clip to [-(2^(WIDTH-1)-1), +(2^(WIDTH-1)-1)] (symmetric; -2^(WIDTH-1) never produced)
//   - sat_cnt++ per clipped transfer
//  LLR_SAT_EN undefined:
//   - conv = s_data >>> (IN_WIDTH-WIDTH), arithmetic shift; -2^(WIDTH-1) is possible
//   - sat_cnt tied 0
// STRUCTURE
//  ldpc_pkg: N, WIDTH, IN_WIDTH defaults, llr_t typedef, loader state enum {IDLE, STREAM}
//  Sub-module llr_bank: 2 x N x WIDTH register file (1 write port, 1 registered read port)
//  Top level holds the FSM, indices, full flags, conversion, counters
// TESTING
//  1 Reset: xrst=0 mid-write and mid-stream -> outputs 0, s_rdy=1 after release,
//    no partial frame emitted
//  2 Single frame, dec_rdy=1, s_data=0..11:
//    o_val 12 clk contiguous, o_sof first, o_eof last, 2 clk after 12th accept,
//    frame_cnt=1; with LLR_SAT_EN o_data=0..11, without o_data=0,0,0,0,1,1,1,1,2,2,2,2
//  3 Backpressure, dec_rdy=0 while 3 frames offered:
//    s_rdy drops after 24 accepts; dec_rdy=1 -> frames in order, s_rdy returns 1 clk after first o_eof
//  4 LLR_SAT_EN, s_data=+127,-128,+31,-31:
//    o_data=+31,-31,+31,-31, sat_cnt=2
//  5 No macro, s_data=-128,+127,-1:
//    o_data=-32,+31,-1, sat_cnt=0
//  6 Continuous s_val=1, dec_rdy=1, 1000 frames:
//    no sample lost/duplicated (scoreboard), frame_cnt=1000

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC decoder front end.
//   N_DEF, IN_WIDTH_DEF, WIDTH_DEF : default codeword length and sample widths
//   llr_t                          : decoder-width signed LLR
//   ld_state_e                     : frame loader read-side state
package ldpc_pkg;

    localparam int N_DEF        = 12;
    localparam int IN_WIDTH_DEF = 8;
    localparam int WIDTH_DEF    = 6;

    typedef logic signed [WIDTH_DEF-1:0] llr_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ld_state_e;

endpackage

// File: rtl/llr_bank.sv
// Ping-pong codeword store: 2 banks x N entries x WIDTH bits.
//   clk, xrst               : clock, async active-low reset (read register only)
//   wr_en/wr_bank/wr_idx/wr_data : single write port
//   rd_en/rd_bank/rd_idx    : read request, data appears on rd_data after the edge
//   rd_data                 : registered read data, holds when rd_en is low
module llr_bank #(
    parameter int N     = 12,
    parameter int WIDTH = 6,
    parameter int IW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [2][N];
    logic [WIDTH-1:0] rd_data_d, rd_data_q;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem_q[rd_bank][rd_idx];
    end

    // Storage is never read before being written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/llr_frame_loader.sv
// LDPC decoder input stage: accepts channel LLRs on a valid/ready stream,
// converts them to decoder width, buffers whole codewords in two ping-pong
// banks and streams each codeword to the decoder one LLR per clock.
//   clk, xrst          : clock, async active-low reset
//   s_data/s_val/s_rdy : input sample stream, sample 0 of a frame first
//   dec_rdy            : decoder may take a new frame (sampled only when idle)
//   o_data/o_val       : LLR to decoder, o_sof/o_eof mark index 0 / N-1
//   frame_cnt          : frames fully streamed (wraps)
//   sat_cnt            : clipped samples (saturates)
// Build option: LLR_SAT_EN selects symmetric clipping instead of an
// arithmetic right shift for the width conversion and enables sat_cnt.
module llr_frame_loader
    import ldpc_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       xrst,
    input  logic signed [IN_WIDTH-1:0] s_data,
    input  logic                       s_val,
    output logic                       s_rdy,
    input  logic                       dec_rdy,
    output logic signed [WIDTH-1:0]    o_data,
    output logic                       o_val,
    output logic                       o_sof,
    output logic                       o_eof,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                sat_cnt
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    ld_state_e         state_q, state_d;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [IW-1:0]     wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [1:0]        full_q, full_d;
    logic              s_rdy_q, s_rdy_d;
    logic              o_val_q, o_val_d, o_sof_q, o_sof_d, o_eof_q, o_eof_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              wr_fire, rd_en;
    logic signed [WIDTH-1:0] conv_data;
    logic [WIDTH-1:0]  bank_rd_data;

    assign wr_fire = s_val && s_rdy_q;

`ifdef LLR_SAT_EN
    // Symmetric clip: the most negative code is never produced.
    localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;

    logic        conv_clip;
    logic [15:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        conv_clip = 1'b1;
        if (s_data > SAT_HI)      conv_data = SAT_HI[WIDTH-1:0];
        else if (s_data < SAT_LO) conv_data = SAT_LO[WIDTH-1:0];
        else begin
            conv_clip = 1'b0;
            conv_data = s_data[WIDTH-1:0];
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (wr_fire && conv_clip && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) sat_cnt_q <= '0;
        else       sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`else
    always_comb begin
        conv_data = WIDTH'(s_data >>> (IN_WIDTH - WIDTH));
    end

    assign sat_cnt = '0;
`endif

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        full_d      = full_q;
        frame_cnt_d = frame_cnt_q;
        o_val_d     = 1'b0;
        o_sof_d     = 1'b0;
        o_eof_d     = 1'b0;
        rd_en       = 1'b0;

        if (wr_fire) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q] && dec_rdy) begin
                    state_d  = STREAM;
                    rd_idx_d = '0;
                end
            end
            STREAM: begin
                rd_en   = 1'b1;
                o_val_d = 1'b1;
                o_sof_d = (rd_idx_q == '0);
                if (rd_idx_q == LAST_IDX) begin
                    o_eof_d           = 1'b1;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    frame_cnt_d       = frame_cnt_q + 16'd1;
                    rd_idx_d          = '0;
                    state_d           = IDLE;
                end else begin
                    rd_idx_d = rd_idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Looks at the current full flags, so a bank freed this cycle opens
        // s_rdy one cycle later; a bank filling this cycle is never the one
        // selected by wr_bank_d, so no write can land in a full bank.
        s_rdy_d = !full_q[wr_bank_d];
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            full_q      <= '0;
            s_rdy_q     <= 1'b0;
            o_val_q     <= 1'b0;
            o_sof_q     <= 1'b0;
            o_eof_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            full_q      <= full_d;
            s_rdy_q     <= s_rdy_d;
            o_val_q     <= o_val_d;
            o_sof_q     <= o_sof_d;
            o_eof_q     <= o_eof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    llr_bank #(.N(N), .WIDTH(WIDTH), .IW(IW)) u_bank (
        .clk     (clk),
        .xrst    (xrst),
        .wr_en   (wr_fire),
        .wr_bank (wr_bank_q),
        .wr_idx  (wr_idx_q),
        .wr_data (conv_data),
        .rd_en   (rd_en),
        .rd_bank (rd_bank_q),
        .rd_idx  (rd_idx_q),
        .rd_data (bank_rd_data)
    );

    assign s_rdy     = s_rdy_q;
    assign o_data    = bank_rd_data;
    assign o_val     = o_val_q;
    assign o_sof     = o_sof_q;
    assign o_eof     = o_eof_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
module tb_llr_frame_loader;

    localparam int N = 12;
`ifdef LLR_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              xrst = 1'b0;
    logic signed [7:0] s_data = '0;
    logic              s_val = 1'b0;
    logic              s_rdy;
    logic              dec_rdy = 1'b0;
    logic signed [5:0] o_data;
    logic              o_val, o_sof, o_eof;
    logic [15:0]       frame_cnt, sat_cnt;

    always #5 clk = ~clk;

    llr_frame_loader dut (
        .clk(clk), .xrst(xrst), .s_data(s_data), .s_val(s_val), .s_rdy(s_rdy),
        .dec_rdy(dec_rdy), .o_data(o_data), .o_val(o_val), .o_sof(o_sof),
        .o_eof(o_eof), .frame_cnt(frame_cnt), .sat_cnt(sat_cnt)
    );

    typedef struct packed {
        logic signed [5:0] d;
        logic              sof;
        logic              eof;
    } exp_t;

    typedef struct {
        int din;
        int e_sat;
        int e_shr;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[N];
    int tests = 0, fails = 0, cyc = 0, wr_pos = 0, accepts = 0, beats = 0;
    int sof_cyc = 0, eof_cyc = 0, last_acc = 0, exp_sat = 0;

    // Reference conversion written independently of the shift/clip form.
    function automatic logic signed [5:0] model(input logic signed [7:0] d);
        int v, r;
        v = int'(d);
        if (SAT_ON) r = (v > 31) ? 31 : ((v < -31) ? -31 : v);
        else        r = (v >= 0) ? (v / 4) : -((-v + 3) / 4);
        return 6'(r);
    endfunction

    function automatic bit clips(input logic signed [7:0] d);
        return SAT_ON && ((int'(d) > 31) || (int'(d) < -31));
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor / scoreboard
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (xrst && o_val) begin
            beats++;
            tests++;
            if (o_sof) sof_cyc = cyc;
            if (o_eof) eof_cyc = cyc;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got d=%0d sof=%0b eof=%0b, expected no output", o_data, o_sof, o_eof);
            end else begin
                e = sb.pop_front();
                if ({o_data, o_sof, o_eof} !== {e.d, e.sof, e.eof}) begin
                    fails++;
                    $display("FAIL sb_beat: got d=%0d sof=%0b eof=%0b, expected d=%0d sof=%0b eof=%0b",
                             o_data, o_sof, o_eof, e.d, e.sof, e.eof);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    // Call at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic signed [7:0] d, input logic signed [5:0] e);
        int n;
        n = 0;
        s_data = d;
        s_val  = 1'b1;
        while (!s_rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!s_rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_rdy=%0b after %0d cycles, expected 1", s_rdy, n);
            s_val = 1'b0;
            return;
        end
        sb.push_back('{d: e, sof: (wr_pos == 0), eof: (wr_pos == N - 1)});
        if (wr_pos == N - 1) last_acc = cyc + 1;
        wr_pos = (wr_pos + 1) % N;
        accepts++;
        if (clips(d)) exp_sat++;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 64'(sb.size()), 0);
    endtask

    task automatic do_reset();
        #2;
        xrst  = 1'b0;
        s_val = 1'b0;
        sb.delete();
        wr_pos  = 0;
        exp_sat = 0;
        #1;
        check("reset_outputs", {o_data, o_val, o_sof, o_eof, s_rdy, frame_cnt, sat_cnt}, 0);
        @(negedge clk);
        xrst  = 1'b1;
        beats = 0;
        #1;
        check("rdy_before_edge", s_rdy, 0);
        @(negedge clk);
        check("rdy_after_release", s_rdy, 1);
    endtask

    initial begin
        logic signed [7:0] d;
        int n;

        tbl = '{'{127, 31, 31}, '{-128, -31, -32}, '{31, 31, 7}, '{-31, -31, -8},
                '{32, 31, 8}, '{-32, -31, -8}, '{0, 0, 0}, '{-1, -1, -1},
                '{1, 1, 0}, '{100, 31, 25}, '{-100, -31, -25}, '{-17, -17, -5}};

        @(negedge clk);
        do_reset();

        // Single frame 0..11, latency and burst shape
        dec_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            d = 8'(i);
            send(d, model(d));
        end
        s_val = 1'b0;
        drain("drain_single");
        check("lat_sof", 64'(sof_cyc - last_acc), 2);
        check("burst_len", 64'(eof_cyc - sof_cyc), N - 1);
        check("frame_cnt_1", frame_cnt, 1);
        check("sat_cnt_1", sat_cnt, 0);

        // Conversion boundary table, hand-computed expectations
        for (int i = 0; i < N; i++) begin
            d = 8'(tbl[i].din);
            send(d, 6'(SAT_ON ? tbl[i].e_sat : tbl[i].e_shr));
        end
        s_val = 1'b0;
        drain("drain_table");
        check("frame_cnt_2", frame_cnt, 2);
        check("sat_cnt_table", sat_cnt, SAT_ON ? 6 : 0);

        // Backpressure: three frames offered with decoder busy
        dec_rdy = 1'b0;
        accepts = 0;
        fork
            begin
                for (int i = 0; i < 3 * N; i++) begin
                    d = 8'(i * 3 - 50);
                    send(d, model(d));
                end
                s_val = 1'b0;
            end
            begin
                int k;
                int b0;
                k  = 0;
                b0 = beats;
                while (accepts < 2 * N && k < 300) begin
                    @(negedge clk);
                    k++;
                end
                repeat (4) @(negedge clk);
                check("bp_accepts", 64'(accepts), 2 * N);
                check("bp_rdy_low", s_rdy, 0);
                check("bp_no_output", 64'(beats - b0), 0);
                dec_rdy = 1'b1;
                k = 0;
                while (!o_eof && k < 100) begin
                    @(negedge clk);
                    k++;
                end
                check("bp_eof_seen", o_eof, 1);
                check("bp_rdy_at_eof", s_rdy, 0);
                @(negedge clk);
                check("bp_rdy_after_eof", s_rdy, 1);
            end
        join
        drain("drain_bp");
        check("frame_cnt_5", frame_cnt, 5);
        check("sat_cnt_bp", sat_cnt, 64'(exp_sat));

        // Reset mid-write: partial frame must never appear
        dec_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'(i + 20);
            send(d, model(d));
        end
        s_val = 1'b0;
        do_reset();
        dec_rdy = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_write_no_output", 64'(beats), 0);
        check("mid_write_frame_cnt", frame_cnt, 0);

        // Reset mid-stream
        for (int i = 0; i < N; i++) begin
            d = 8'(40 - i);
            send(d, model(d));
        end
        s_val = 1'b0;
        n = 0;
        while (!o_val && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_stream_started", o_val, 1);
        repeat (3) @(negedge clk);
        do_reset();
        repeat (30) @(negedge clk);
        check("mid_stream_no_output", 64'(beats), 0);

        // Continuous traffic, 1000 frames
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < N; i++) begin
                d = 8'($urandom_range(255));
                send(d, model(d));
            end
        end
        s_val = 1'b0;
        drain("drain_stream");
        check("frame_cnt_1000", frame_cnt, 1000);
        check("sat_cnt_stream", sat_cnt, 64'(exp_sat));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
